// File: rtl/param_queue.sv
// Bounded WIDTH x DEPTH word queue with compile-time FIFO/LIFO ordering,
// synchronous clear, occupancy status and sticky overflow/underflow flags.
module param_queue #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int LIFO      = 0,
    parameter int AF_THRESH = 6,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enq_in,
    input  logic             deq_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [LW-1:0]    len_out,
    output logic             empty_out,
    output logic             full_out,
    output logic             almost_full_out,
    output logic             ovf_out,
    output logic             udf_out
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_idx;
    logic [PW-1:0]    wr_idx;
    logic [LW-1:0]    len;
    logic             do_enq;
    logic             do_deq;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A dequeue frees a slot in the same cycle, so enq+deq is accepted even when full.
    always_comb begin
        do_deq = deq_in && (len != '0) && !clear_in;
        do_enq = enq_in && ((len != LW'(DEPTH)) || do_deq) && !clear_in;
        if (LIFO != 0) begin
            rd_idx = PW'(len - LW'(1));
            wr_idx = do_deq ? rd_idx : PW'(len);
        end else begin
            rd_idx = rd_ptr;
            wr_idx = wr_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            len       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
            udf_out   <= 1'b0;
        end else if (clear_in) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            len       <= '0;
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
            udf_out   <= 1'b0;
        end else begin
            valid_out <= do_deq;
            if (do_deq) begin
                data_out <= mem[rd_idx];
                rd_ptr   <= bump(rd_ptr);
            end
            if (do_enq) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_enq && !do_deq) begin
                len <= len + LW'(1);
            end else if (do_deq && !do_enq) begin
                len <= len - LW'(1);
            end
            if (enq_in && !do_enq) begin
                ovf_out <= 1'b1;
            end
            if (deq_in && (len == '0)) begin
                udf_out <= 1'b1;
            end
        end
    end

    assign len_out         = len;
    assign empty_out       = (len == '0);
    assign full_out        = (len == LW'(DEPTH));
    assign almost_full_out = (len >= LW'(AF_THRESH));

endmodule

// File: tb/tb_param_queue.sv
// Directed self-checking bench for param_queue: one FIFO and one LIFO instance
// driven from hand-written vectors with hand-computed expectations.
module tb_param_queue;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       f_clear = 1'b0, f_enq = 1'b0, f_deq = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_valid, f_empty, f_full, f_af, f_ovf, f_udf;
    logic [3:0] f_len;

    logic       l_clear = 1'b0, l_enq = 1'b0, l_deq = 1'b0;
    logic [7:0] l_din = '0, l_dout;
    logic       l_valid, l_empty, l_full, l_af, l_ovf, l_udf;
    logic [3:0] l_len;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    param_queue #(.WIDTH(8), .DEPTH(8), .LIFO(0), .AF_THRESH(6)) u_fifo (
        .clock(clock), .reset(reset), .clear_in(f_clear), .data_in(f_din),
        .enq_in(f_enq), .deq_in(f_deq), .data_out(f_dout), .valid_out(f_valid),
        .len_out(f_len), .empty_out(f_empty), .full_out(f_full),
        .almost_full_out(f_af), .ovf_out(f_ovf), .udf_out(f_udf)
    );

    param_queue #(.WIDTH(8), .DEPTH(8), .LIFO(1), .AF_THRESH(6)) u_lifo (
        .clock(clock), .reset(reset), .clear_in(l_clear), .data_in(l_din),
        .enq_in(l_enq), .deq_in(l_deq), .data_out(l_dout), .valid_out(l_valid),
        .len_out(l_len), .empty_out(l_empty), .full_out(l_full),
        .almost_full_out(l_af), .ovf_out(l_ovf), .udf_out(l_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic f_drive(input logic enq, input logic deq, input logic [7:0] d);
        f_enq = enq;
        f_deq = deq;
        f_din = d;
        tick();
        f_enq = 1'b0;
        f_deq = 1'b0;
    endtask

    task automatic l_drive(input logic enq, input logic deq, input logic [7:0] d);
        l_enq = enq;
        l_deq = deq;
        l_din = d;
        tick();
        l_enq = 1'b0;
        l_deq = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_len", f_len, 0);
        check("rst_empty", f_empty, 1);
        check("rst_full", f_full, 0);
        check("rst_af", f_af, 0);
        check("rst_valid", f_valid, 0);
        check("rst_dout", f_dout, 0);
        check("rst_ovf", f_ovf, 0);
        check("rst_udf", f_udf, 0);
        check("rst_l_empty", l_empty, 1);
        reset = 1'b0;
        tick();

        // T1: fill FIFO, then overflow
        for (int i = 0; i < 8; i++) begin
            f_drive(1, 0, 8'(8'h11 * (i + 1)));
            check("t1_len", f_len, i + 1);
            check("t1_af", f_af, (i + 1 >= 6) ? 1 : 0);
            check("t1_full", f_full, (i == 7) ? 1 : 0);
            check("t1_empty", f_empty, 0);
        end
        check("t1_ovf_pre", f_ovf, 0);
        f_drive(1, 0, 8'h99);
        check("t1_ovf", f_ovf, 1);
        check("t1_len_ovf", f_len, 8);
        check("t1_full_ovf", f_full, 1);

        // T2: drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            f_drive(0, 1, 8'h00);
            check("t2_valid", f_valid, 1);
            check("t2_dout", f_dout, 8'h11 * (i + 1));
            check("t2_len", f_len, 7 - i);
            tick();
            check("t2_valid_pulse", f_valid, 0);
            check("t2_dout_hold", f_dout, 8'h11 * (i + 1));
        end
        check("t2_empty", f_empty, 1);
        f_drive(0, 1, 8'h00);
        check("t2_udf", f_udf, 1);
        check("t2_udf_valid", f_valid, 0);
        check("t2_udf_dout", f_dout, 8'h88);
        check("t2_ovf_sticky", f_ovf, 1);

        // Synchronous clear keeps data_out, drops flags
        f_clear = 1'b1;
        tick();
        f_clear = 1'b0;
        check("clr_ovf", f_ovf, 0);
        check("clr_udf", f_udf, 0);
        check("clr_len", f_len, 0);
        check("clr_dout", f_dout, 8'h88);

        // T3: steady enq+deq at len 3 across pointer wrap
        for (int i = 0; i < 3; i++) f_drive(1, 0, 8'(i + 1));
        for (int r = 0; r < 20; r++) begin
            f_drive(1, 1, 8'(8'h04 + r));
            check("t3_dout", f_dout, 8'h01 + r);
            check("t3_valid", f_valid, 1);
            check("t3_len", f_len, 3);
        end
        for (int i = 0; i < 3; i++) begin
            f_drive(0, 1, 8'h00);
            check("t3_drain", f_dout, 8'h15 + i);
        end
        check("t3_empty", f_empty, 1);

        // Simultaneous enq+deq while full
        for (int i = 0; i < 8; i++) f_drive(1, 0, 8'(8'h30 + i));
        f_drive(1, 1, 8'h38);
        check("full_ed_dout", f_dout, 8'h30);
        check("full_ed_len", f_len, 8);
        check("full_ed_ovf", f_ovf, 0);
        for (int i = 0; i < 8; i++) begin
            f_drive(0, 1, 8'h00);
            check("full_ed_drain", f_dout, 8'h31 + i);
        end

        // T5: enq+deq at len 0 is enq plus underflow, no bypass
        f_drive(1, 1, 8'h5A);
        check("t5_len", f_len, 1);
        check("t5_udf", f_udf, 1);
        check("t5_valid", f_valid, 0);
        check("t5_dout", f_dout, 8'h38);
        tick();
        check("t5_nobypass", f_dout, 8'h38);
        f_drive(0, 1, 8'h00);
        check("t5_deq", f_dout, 8'h5A);
        check("t5_deq_valid", f_valid, 1);
        check("t5_deq_len", f_len, 0);

        // T4: LIFO order, including enq+deq replacing the top
        for (int i = 0; i < 3; i++) l_drive(1, 0, 8'(8'hA1 + i));
        check("t4_len", l_len, 3);
        l_drive(1, 1, 8'hB0);
        check("t4_swap_dout", l_dout, 8'hA3);
        check("t4_swap_len", l_len, 3);
        l_drive(0, 1, 8'h00);
        check("t4_pop0", l_dout, 8'hB0);
        l_drive(0, 1, 8'h00);
        check("t4_pop1", l_dout, 8'hA2);
        l_drive(0, 1, 8'h00);
        check("t4_pop2", l_dout, 8'hA1);
        check("t4_empty", l_empty, 1);
        l_drive(0, 1, 8'h00);
        check("t4_udf", l_udf, 1);
        check("t4_udf_valid", l_valid, 0);
        for (int i = 0; i < 8; i++) l_drive(1, 0, 8'(8'hC0 + i));
        l_drive(1, 0, 8'hEE);
        check("t4_ovf", l_ovf, 1);
        l_drive(1, 1, 8'hD0);
        check("t4_full_swap", l_dout, 8'hC7);
        check("t4_full_len", l_len, 8);
        l_drive(0, 1, 8'h00);
        check("t4_full_pop", l_dout, 8'hD0);
        l_drive(0, 1, 8'h00);
        check("t4_full_pop2", l_dout, 8'hC6);

        // T6: asynchronous reset mid-burst, then clear with enq
        f_drive(1, 0, 8'h61);
        f_enq = 1'b1;
        f_din = 8'h62;
        #2 reset = 1'b1;
        #1;
        check("t6_async_len", f_len, 0);
        check("t6_async_empty", f_empty, 1);
        check("t6_async_dout", f_dout, 0);
        reset = 1'b0;
        f_enq = 1'b0;
        f_drive(0, 1, 8'h00);
        check("t6_udf_set", f_udf, 1);
        check("t6_discarded", f_valid, 0);
        f_clear = 1'b1;
        f_drive(1, 0, 8'h77);
        f_clear = 1'b0;
        check("t6_clr_len", f_len, 0);
        check("t6_clr_empty", f_empty, 1);
        check("t6_clr_udf", f_udf, 0);
        check("t6_clr_ovf", f_ovf, 0);
        f_drive(0, 1, 8'h00);
        check("t6_not_stored", f_valid, 0);
        check("t6_not_stored_udf", f_udf, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
